// File: rtl/udp_panel_stream_writer.sv
// UDP payload to LED-panel write port: decodes a header beat, then turns pixel
// beats into per-panel RGB888 writes with explicit or auto-increment addressing.
module udp_panel_stream_writer #(
    parameter logic [7:0]  PORT_MSB   = 8'h80,
    parameter int unsigned NUM_PANELS = 8,
    parameter int unsigned ADDR_W     = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  udp_source_valid,
    input  logic                  udp_source_last,
    output logic                  udp_source_ready,
    input  logic [15:0]           udp_source_dst_port,
    input  logic [31:0]           udp_source_data,
    input  logic [3:0]            udp_source_error,
    output logic [NUM_PANELS-1:0] ctrl_en,
    output logic [ADDR_W-1:0]     ctrl_addr,
    output logic [23:0]           ctrl_wdat,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count,
    output logic                  led_reg
);

    localparam int unsigned PIX_W = 32 - ADDR_W;
    localparam int unsigned CH_W  = PIX_W / 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        START_ADDR = 2'd1,
        PIXELS     = 2'd2,
        DISCARD    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_PANELS-1:0] mask_q, mask_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PANELS-1:0] en_q, en_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [23:0]           wdat_q, wdat_d;
    logic [15:0]           pkt_q, pkt_d;
    logic [15:0]           drop_q, drop_d;
    logic                  led_q, led_d;

    logic [31:0]      w_c;
    logic             accept_c;
    logic             err_c;
    logic             hdr_bad_c;
    logic             pkt_inc_c;
    logic             drop_inc_c;
    logic [PIX_W-1:0] pix_c;
    logic [23:0]      pix_wdat_c;
    logic             unused_c;

    // Channel MSB-justified into a byte; channels wider than 8 keep their top bits.
    function automatic logic [7:0] ch_to_byte(input logic [CH_W-1:0] ch);
        logic [15:0] t;
        t = 16'(ch) << (16 - CH_W);
        return t[15:8];
    endfunction

    assign udp_source_ready = ~reset;
    assign accept_c         = udp_source_valid & udp_source_ready;
    assign err_c            = |udp_source_error;
    assign w_c              = {udp_source_data[7:0], udp_source_data[15:8],
                               udp_source_data[23:16], udp_source_data[31:24]};
    assign hdr_bad_c        = (udp_source_dst_port[15:8] != PORT_MSB) | err_c | w_c[17];
    assign pix_c            = w_c[PIX_W-1:0];
    assign pix_wdat_c       = {ch_to_byte(pix_c[PIX_W-1 -: CH_W]),
                               ch_to_byte(pix_c[2*CH_W-1 -: CH_W]),
                               ch_to_byte(pix_c[CH_W-1:0])};
    assign unused_c         = ^udp_source_dst_port[7:0];

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        en_d       = '0;
        addr_d     = addr_q;
        wdat_d     = wdat_q;
        pkt_inc_c  = 1'b0;
        drop_inc_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (udp_source_last) begin
                        drop_inc_c = 1'b1;
                    end else if (hdr_bad_c) begin
                        drop_inc_c = 1'b1;
                        state_d    = DISCARD;
                    end else begin
                        mask_d  = w_c[NUM_PANELS-1:0];
                        mode_d  = w_c[17:16];
                        state_d = w_c[16] ? START_ADDR : PIXELS;
                    end
                end
            end
            START_ADDR: begin
                if (accept_c) begin
                    if (err_c || udp_source_last) begin
                        drop_inc_c = 1'b1;
                        state_d    = udp_source_last ? IDLE : DISCARD;
                    end else begin
                        cnt_d   = w_c[ADDR_W-1:0];
                        state_d = PIXELS;
                    end
                end
            end
            PIXELS: begin
                if (accept_c) begin
                    if (err_c) begin
                        drop_inc_c = 1'b1;
                        state_d    = udp_source_last ? IDLE : DISCARD;
                    end else begin
                        en_d = mask_q;
                        if (mode_q == 2'd0) begin
                            addr_d = w_c[31 -: ADDR_W];
                            wdat_d = pix_wdat_c;
                        end else begin
                            addr_d = cnt_q;
                            wdat_d = w_c[23:0];
                            cnt_d  = cnt_q + ADDR_W'(1);
                        end
                        if (udp_source_last) begin
                            pkt_inc_c = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (accept_c && udp_source_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pkt_d  = (pkt_inc_c && pkt_q != 16'hFFFF) ? pkt_q + 16'd1 : pkt_q;
        drop_d = (drop_inc_c && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        led_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            en_q    <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            pkt_q   <= '0;
            drop_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
            led_q   <= led_d;
        end
    end

    assign ctrl_en    = en_q;
    assign ctrl_addr  = addr_q;
    assign ctrl_wdat  = wdat_q;
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
    assign led_reg    = led_q;

endmodule

// File: tb/tb_udp_panel_stream_writer.sv
// Bench for udp_panel_stream_writer: packet-level expectation model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_udp_panel_stream_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        udp_source_valid;
    logic        udp_source_last;
    logic        udp_source_ready;
    logic [15:0] udp_source_dst_port;
    logic [31:0] udp_source_data;
    logic [3:0]  udp_source_error;
    logic [7:0]  ctrl_en;
    logic [13:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic [15:0] pkt_count;
    logic [15:0] drop_count;
    logic        led_reg;

    always #5 clk = ~clk;

    udp_panel_stream_writer #(
        .PORT_MSB   (8'h80),
        .NUM_PANELS (8),
        .ADDR_W     (14)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .udp_source_valid    (udp_source_valid),
        .udp_source_last     (udp_source_last),
        .udp_source_ready    (udp_source_ready),
        .udp_source_dst_port (udp_source_dst_port),
        .udp_source_data     (udp_source_data),
        .udp_source_error    (udp_source_error),
        .ctrl_en             (ctrl_en),
        .ctrl_addr           (ctrl_addr),
        .ctrl_wdat           (ctrl_wdat),
        .pkt_count           (pkt_count),
        .drop_count          (drop_count),
        .led_reg             (led_reg)
    );

    int checks   = 0;
    int failures = 0;

    // Expected outputs for the interval following the next rising edge
    logic [7:0]  exp_en;
    logic [13:0] exp_addr;
    logic [23:0] exp_wdat;
    logic [15:0] exp_pkt;
    logic [15:0] exp_drop;
    logic        exp_led;
    logic        exp_ready;
    bit          chk_en = 1'b0;

    typedef struct packed {
        logic [7:0]  en;
        logic [13:0] addr;
        logic [23:0] wdat;
    } wr_t;
    wr_t wr_log[$];

    logic [31:0] pw[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                chk("ready",      32'(udp_source_ready), 32'(exp_ready));
                chk("ctrl_en",    32'(ctrl_en),          32'(exp_en));
                chk("ctrl_addr",  32'(ctrl_addr),        32'(exp_addr));
                chk("ctrl_wdat",  32'(ctrl_wdat),        32'(exp_wdat));
                chk("pkt_count",  32'(pkt_count),        32'(exp_pkt));
                chk("drop_count", 32'(drop_count),       32'(exp_drop));
                chk("led_reg",    32'(led_reg),          32'(exp_led));
            end
            if (ctrl_en != 8'h00) wr_log.push_back('{ctrl_en, ctrl_addr, ctrl_wdat});
        end
    end

    task automatic idle_cyc();
        @(negedge clk);
        udp_source_valid = 1'b0;
        udp_source_last  = 1'b0;
        udp_source_data  = $urandom;
        exp_en           = 8'h00;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset            = 1'b1;
        udp_source_valid = 1'b0;
        udp_source_last  = 1'b0;
        exp_ready = 1'b0;
        exp_en    = '0;
        exp_addr  = '0;
        exp_wdat  = '0;
        exp_pkt   = '0;
        exp_drop  = '0;
        exp_led   = 1'b0;
        repeat (cycles - 1) @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        exp_ready = 1'b1;
    endtask

    // Sends pw[0..n_send-1] (network-order words) of a packet; the whole
    // packet's fate is decided up front from its header, length and error beat.
    task automatic run_packet(input logic [15:0] port, input int err_beat,
                              input int gap, input int n_send);
        int          n;
        int          ns;
        int          fp;
        int          drop_beat;
        logic [31:0] hdr;
        logic [7:0]  mask;
        logic [1:0]  mode;
        logic [13:0] start;
        logic [31:0] w;
        bit          wr;
        n    = pw.size();
        ns   = (n_send < 0) ? n : n_send;
        hdr  = pw[0];
        mask = hdr[7:0];
        mode = hdr[17:16];
        fp   = (mode == 2'd0) ? 1 : 2;
        start = (n > 1) ? pw[1][13:0] : 14'h0;
        drop_beat = -1;
        if (port[15:8] != 8'h80 || err_beat == 0 || mode > 2'd1 || n == 1) drop_beat = 0;
        else if (err_beat >= 1) drop_beat = err_beat;
        else if (mode == 2'd1 && n == 2) drop_beat = 1;
        for (int i = 0; i < ns; i++) begin
            if (i > 0) repeat (gap) idle_cyc();
            @(negedge clk);
            w  = pw[i];
            wr = (drop_beat < 0 || i < drop_beat) && i >= fp;
            if (wr) begin
                exp_en = mask;
                if (mode == 2'd0) begin
                    exp_addr = w[31:18];
                    exp_wdat = {w[17:12], 2'b00, w[11:6], 2'b00, w[5:0], 2'b00};
                end else begin
                    exp_addr = 14'(int'(start) + (i - fp));
                    exp_wdat = w[23:0];
                end
            end else begin
                exp_en = 8'h00;
            end
            if (i == drop_beat) exp_drop = exp_drop + 16'd1;
            if (i == n - 1 && drop_beat < 0) exp_pkt = exp_pkt + 16'd1;
            exp_led = (i != n - 1);
            udp_source_valid    = 1'b1;
            udp_source_last     = (i == n - 1);
            udp_source_dst_port = port;
            udp_source_data     = bswap(w);
            udp_source_error    = (i == err_beat) ? 4'h1 : 4'h0;
        end
        if (ns == n) idle_cyc();
    endtask

    logic [31:0] px;

    initial begin
        reset               = 1'b1;
        udp_source_valid    = 1'b0;
        udp_source_last     = 1'b0;
        udp_source_dst_port = 16'h0000;
        udp_source_data     = 32'h0;
        udp_source_error    = 4'h0;
        exp_ready = 1'b0;
        exp_en    = '0;
        exp_addr  = '0;
        exp_wdat  = '0;
        exp_pkt   = '0;
        exp_drop  = '0;
        exp_led   = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        do_reset(2);
        chk("rst_pkt_count", 32'(pkt_count), 32'h0);
        chk("rst_ctrl_addr", 32'(ctrl_addr), 32'h0);

        // Mode 1 across the address wrap
        wr_log.delete();
        pw = {32'h0001_0005, 32'h0000_3FFE, 32'h00AA_1111, 32'h00BB_2222, 32'h00CC_3333};
        run_packet(16'h8000, -1, 0, -1);
        chk("s1_n_writes", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) begin
            chk("s1_addr0", 32'(wr_log[0].addr), 32'h3FFE);
            chk("s1_addr1", 32'(wr_log[1].addr), 32'h3FFF);
            chk("s1_addr2", 32'(wr_log[2].addr), 32'h0000);
            chk("s1_en2",   32'(wr_log[2].en),   32'h05);
            chk("s1_wdat2", 32'(wr_log[2].wdat), 32'hCC3333);
        end
        chk("s1_pkt_count", 32'(pkt_count), 32'd1);

        // Mode 0 explicit address, channel packing
        do_reset(1);
        wr_log.delete();
        px = {14'h1234, 6'h3F, 6'h00, 6'h21};
        pw = {32'h0000_0003, px};
        run_packet(16'h80AB, -1, 0, -1);
        chk("s2_n_writes", 32'(wr_log.size()), 32'd1);
        if (wr_log.size() == 1) begin
            chk("s2_addr", 32'(wr_log[0].addr), 32'h1234);
            chk("s2_wdat", 32'(wr_log[0].wdat), 32'hFC0084);
        end

        // Wrong port dropped, next packet written
        do_reset(1);
        wr_log.delete();
        pw = {32'h0000_00FF, 32'h0001_0000, 32'h0002_0000};
        run_packet(16'h8100, -1, 0, -1);
        chk("s3_no_write", 32'(wr_log.size()), 32'd0);
        chk("s3_drop", 32'(drop_count), 32'd1);
        pw = {32'h0000_0010, 32'hABCD_0FFF};
        run_packet(16'h8000, -1, 0, -1);
        chk("s3_after_write", 32'(wr_log.size()), 32'd1);

        // Error on third pixel of five
        do_reset(1);
        wr_log.delete();
        pw = {32'h0000_0022, 32'h0004_1041, 32'h0008_2082, 32'h000C_30C3,
              32'h0010_4104, 32'h0014_5145};
        run_packet(16'h8000, 3, 0, -1);
        chk("s4_writes", 32'(wr_log.size()), 32'd2);
        chk("s4_drop", 32'(drop_count), 32'd1);
        chk("s4_pkt", 32'(pkt_count), 32'd0);
        chk("s4_led", 32'(led_reg), 32'd0);

        // Valid gaps between auto-increment pixels
        do_reset(1);
        wr_log.delete();
        pw = {32'h0001_0081, 32'h0000_0100, 32'h0011_2233, 32'h0044_5566, 32'h0077_8899};
        run_packet(16'h8000, -1, 2, -1);
        chk("s5_writes", 32'(wr_log.size()), 32'd3);
        if (wr_log.size() == 3) chk("s5_addr2", 32'(wr_log[2].addr), 32'h0102);

        // Reset mid-packet, then a fresh packet
        do_reset(1);
        pw = {32'h0000_0007, 32'h0400_0FC0, 32'h0800_003F, 32'h0C00_0000};
        run_packet(16'h8000, -1, 0, 3);
        do_reset(2);
        chk("s6_rst_en", 32'(ctrl_en), 32'h0);
        wr_log.delete();
        pw = {32'h0000_0001, 32'hFFFF_FFFF};
        run_packet(16'h8000, -1, 0, -1);
        chk("s6_pkt", 32'(pkt_count), 32'd1);
        chk("s6_drop", 32'(drop_count), 32'd0);
        chk("s6_writes", 32'(wr_log.size()), 32'd1);

        // Drop corner cases followed by recovery
        do_reset(1);
        pw = {32'h0000_00FF};
        run_packet(16'h8000, -1, 0, -1);
        pw = {32'h0001_00FF, 32'h0000_0010};
        run_packet(16'h8000, -1, 0, -1);
        pw = {32'h0002_00FF, 32'h0000_0001, 32'h0000_0002};
        run_packet(16'h8000, -1, 1, -1);
        pw = {32'h0000_00FF, 32'h0000_0001, 32'h0000_0002};
        run_packet(16'h8000, 0, 0, -1);
        pw = {32'h0001_00FF, 32'h0000_0020, 32'h0000_0001, 32'h0000_0002};
        run_packet(16'h8000, 1, 0, -1);
        pw = {32'h0000_0040, 32'h0000_0001, 32'h0004_0002};
        run_packet(16'h8000, -1, 0, -1);
        chk("s7_drop", 32'(drop_count), 32'd5);
        chk("s7_pkt", 32'(pkt_count), 32'd1);

        idle_cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
